// File: rtl/drop_pkg.sv
// Shared state and status encodings for the baggage-drop station controller.
package drop_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_MEASURE = 3'd1;
    localparam logic [2:0] S_READY   = 3'd2;
    localparam logic [2:0] S_DROP    = 3'd3;
    localparam logic [2:0] S_REJECT  = 3'd4;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_MEAS = 2'b01;
    localparam logic [1:0] ST_DROP = 2'b10;
    localparam logic [1:0] ST_REJ  = 2'b11;

    // READY shares the MEASURE code; height_valid tells the two apart.
    function automatic logic [1:0] status_of(input logic [2:0] state);
        case (state)
            S_MEASURE, S_READY: status_of = ST_MEAS;
            S_DROP:             status_of = ST_DROP;
            S_REJECT:           status_of = ST_REJ;
            default:            status_of = ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/baggage_drop_ctrl_if.sv
// Sensor handshake and station status bundle between the station and its controller.
interface baggage_drop_ctrl_if #(
    parameter int W = 8
);
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] sensor1;
    logic [W-1:0] sensor2;
    logic [W-1:0] sensor3;
    logic [W-1:0] sensor4;
    logic         drop_req;
    logic [W-1:0] height;
    logic         height_valid;
    logic         drop_open;
    logic [1:0]   status;
    logic [15:0]  drop_count;

    modport master (
        output s_valid, sensor1, sensor2, sensor3, sensor4, drop_req,
        input  s_ready, height, height_valid, drop_open, status, drop_count
    );

    modport slave (
        input  s_valid, sensor1, sensor2, sensor3, sensor4, drop_req,
        output s_ready, height, height_valid, drop_open, status, drop_count
    );
endinterface

// File: rtl/height_calc.sv
// Rounded baggage height from four sensor readings; a zero on either diagonal
// pair means that pair is blocked and the opposite pair is averaged instead.
module height_calc #(
    parameter int W = 8
) (
    input  logic [W-1:0] sensor1,
    input  logic [W-1:0] sensor2,
    input  logic [W-1:0] sensor3,
    input  logic [W-1:0] sensor4,
    output logic [W-1:0] h
);
    logic [W:0]   sum_24;
    logic [W:0]   sum_13;
    logic [W+1:0] sum_all;
    logic [W+1:0] avg_all;

    always_comb begin
        sum_24  = {1'b0, sensor2} + {1'b0, sensor4} + (W+1)'(1);
        sum_13  = {1'b0, sensor1} + {1'b0, sensor3} + (W+1)'(1);
        sum_all = {2'b00, sensor1} + {2'b00, sensor2} + {2'b00, sensor3} + {2'b00, sensor4};
        avg_all = (sum_all >> 2) + (W+2)'(sum_all[1]);
        if (sensor1 == '0 || sensor3 == '0) begin
            h = W'(sum_24 >> 1);
        end else if (sensor2 == '0 || sensor4 == '0) begin
            h = W'(sum_13 >> 1);
        end else begin
            h = W'(avg_all);
        end
    end
endmodule

// File: rtl/baggage_drop_ctrl.sv
// Baggage-drop station sequencer: waits for a stable height, accepts or rejects
// the item, and times the drop door while counting completed drops.
module baggage_drop_ctrl
    import drop_pkg::*;
#(
    parameter int W           = 8,
    parameter int STABLE_CNT  = 3,
    parameter int MAX_HEIGHT  = 200,
    parameter int DOOR_CYCLES = 16,
    parameter int REJECT_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    baggage_drop_ctrl_if.slave bus
);
    localparam int SW   = $clog2(STABLE_CNT + 1);
    localparam int CMAX = (DOOR_CYCLES > REJECT_HOLD) ? DOOR_CYCLES : REJECT_HOLD;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [SW-1:0] STAB_TGT  = SW'(STABLE_CNT);
    localparam logic [W-1:0]  MAX_H     = W'(MAX_HEIGHT);
    localparam logic [CW-1:0] DOOR_LOAD = CW'(DOOR_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(REJECT_HOLD - 1);

    logic [2:0]    state_q, state_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  height_q, height_d;
    logic          height_valid_q, height_valid_d;
    logic          drop_open_q, drop_open_d;
    logic          s_ready_q, s_ready_d;
    logic [15:0]   drop_count_q, drop_count_d;
    logic [W-1:0]  h;
    logic          accept;
    logic [SW-1:0] stab_next;

    height_calc #(.W(W)) u_height_calc (
        .sensor1 (bus.sensor1),
        .sensor2 (bus.sensor2),
        .sensor3 (bus.sensor3),
        .sensor4 (bus.sensor4),
        .h       (h)
    );

    assign accept = bus.s_valid && s_ready_q;

    // stab_next is nonzero only when this edge extends or restarts a run; the
    // shared tail then either keeps measuring or registers the decision.
    always_comb begin
        state_d        = state_q;
        stab_d         = stab_q;
        cnt_d          = cnt_q;
        height_d       = height_q;
        height_valid_d = height_valid_q;
        drop_open_d    = drop_open_q;
        drop_count_d   = drop_count_q;
        stab_next      = '0;

        case (state_q)
            S_IDLE: begin
                if (accept && h != '0) begin
                    height_d  = h;
                    stab_next = SW'(1);
                end
            end
            S_MEASURE: begin
                if (accept) begin
                    if (h == '0) begin
                        state_d = S_IDLE;
                        stab_d  = '0;
                    end else if (h != height_q) begin
                        height_d  = h;
                        stab_next = SW'(1);
                    end else begin
                        stab_next = stab_q + SW'(1);
                    end
                end
            end
            S_READY: begin
                if (bus.drop_req) begin
                    state_d     = S_DROP;
                    drop_open_d = 1'b1;
                    cnt_d       = DOOR_LOAD;
                end
            end
            S_DROP: begin
                if (cnt_q == '0) begin
                    state_d        = S_IDLE;
                    drop_open_d    = 1'b0;
                    height_valid_d = 1'b0;
                    if (drop_count_q != 16'hFFFF) begin
                        drop_count_d = drop_count_q + 16'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_REJECT: begin
                if (cnt_q == '0) begin
                    state_d        = S_IDLE;
                    height_valid_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (stab_next != '0) begin
            if (stab_next >= STAB_TGT) begin
                stab_d         = '0;
                height_valid_d = 1'b1;
                if (h <= MAX_H) begin
                    state_d = S_READY;
                end else begin
                    state_d = S_REJECT;
                    cnt_d   = HOLD_LOAD;
                end
            end else begin
                stab_d  = stab_next;
                state_d = S_MEASURE;
            end
        end

        s_ready_d = (state_d == S_IDLE) || (state_d == S_MEASURE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            stab_q         <= '0;
            cnt_q          <= '0;
            height_q       <= '0;
            height_valid_q <= 1'b0;
            drop_open_q    <= 1'b0;
            s_ready_q      <= 1'b0;
            drop_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            stab_q         <= stab_d;
            cnt_q          <= cnt_d;
            height_q       <= height_d;
            height_valid_q <= height_valid_d;
            drop_open_q    <= drop_open_d;
            s_ready_q      <= s_ready_d;
            drop_count_q   <= drop_count_d;
        end
    end

    assign bus.s_ready      = s_ready_q;
    assign bus.height       = height_q;
    assign bus.height_valid = height_valid_q;
    assign bus.drop_open    = drop_open_q;
    assign bus.status       = status_of(state_q);
    assign bus.drop_count   = drop_count_q;
endmodule
